// File: rtl/tdm_receiver8_if.sv
// Link bundle between tdm_receiver8 and its distributor/downstream side.
// oLineErr exists only when TDM_LINE_CHECK_EN is defined.
interface tdm_receiver8_if;
  logic       iEnable;
  logic [7:0] iLines;
  logic       oA;
  logic       oB;
  logic       oC;
  logic [7:0] oData;
  logic       oValid;
  logic       iReady;
  logic       oOverrun;
`ifdef TDM_LINE_CHECK_EN
  logic       oLineErr;
`endif

  modport master (
    input  iEnable, iLines, iReady,
`ifdef TDM_LINE_CHECK_EN
    output oLineErr,
`endif
    output oA, oB, oC, oData, oValid, oOverrun
  );

  modport slave (
    output iEnable, iLines, iReady,
`ifdef TDM_LINE_CHECK_EN
    input  oLineErr,
`endif
    input  oA, oB, oC, oData, oValid, oOverrun
  );
endinterface

// File: rtl/tdm_receiver8.sv
// TDM receiver: scans 8 distributor lines via select {oA,oB,oC}, assembles one word per frame.
// Optional idle-line checking (oLineErr) is enabled by defining TDM_LINE_CHECK_EN.
module tdm_receiver8 #(
  parameter int unsigned SLOT_CYCLES = 1  // legal range 1..16
) (
  input  logic            clk,
  input  logic            rst_n,
  tdm_receiver8_if.master bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [3:0] DWELL_LAST = 4'(SLOT_CYCLES - 1);

  state_t     state;
  logic [2:0] slot;
  logic [3:0] dwell;
  logic [7:0] shreg;
  logic [7:0] data;
  logic       valid;
  logic       overrun;

  logic       sample;
  logic       frame_done;
  logic [7:0] word;

  always_comb begin
    sample     = (state == SCAN) && (dwell == DWELL_LAST);
    frame_done = sample && (slot == 3'd7);
    // Assembled word including the bit captured on this edge.
    word       = shreg;
    word[slot] = bus.iLines[slot];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      slot    <= '0;
      dwell   <= '0;
      shreg   <= '0;
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (valid && bus.iReady)
        valid <= 1'b0;

      // A completing frame is delivered even if iEnable drops on this edge.
      if (frame_done) begin
        if (!valid || bus.iReady) begin
          data  <= word;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          slot  <= '0;
          dwell <= '0;
          if (bus.iEnable)
            state <= SCAN;
        end
        SCAN: begin
          if (!bus.iEnable) begin
            state <= IDLE;
            slot  <= '0;
            dwell <= '0;
            shreg <= '0;
          end else if (sample) begin
            shreg <= word;
            dwell <= '0;
            slot  <= slot + 3'd1;
          end else begin
            dwell <= dwell + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TDM_LINE_CHECK_EN
  logic line_err;

  // Every non-selected line must idle high at each sample point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      line_err <= 1'b0;
    else if (sample && ((bus.iLines | (8'(1) << slot)) != '1))
      line_err <= 1'b1;
  end

  assign bus.oLineErr = line_err;
`endif

  assign bus.oA       = slot[2];
  assign bus.oB       = slot[1];
  assign bus.oC       = slot[0];
  assign bus.oData    = data;
  assign bus.oValid   = valid;
  assign bus.oOverrun = overrun;

endmodule

// File: doc/tdm_receiver8.md
Name: tdm_receiver8

Overview:
- Receiving end of the 8-line select-and-pass link: this block drives the 3-bit channel select (A,B,C) into the 1-of-8 line distributor and samples the selected line.
- The distributor's idle lines sit at 1; the selected line carries iData[k].
- Scans slots 0..7 in order and reassembles one 8-bit word per frame.
- Presents each word on a valid/ready output register toward downstream logic (display or register file).

Parameters:
- SLOT_CYCLES, 1, clock cycles each select value is held before sampling; legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- iEnable  input  1  run scanning; level-sensitive.
- iLines  input  8  the distributor's 8 output lines; the selected line holds data, the others idle at 1.
- oA  output  1  select bit 2 (MSB).
- oB  output  1  select bit 1.
- oC  output  1  select bit 0 (LSB).
- oData  output  8  assembled word, bit k taken from slot k.
- oValid  output  1  oData holds an unconsumed word.
- iReady  input  1  downstream accepts the word while oValid=1.
- oOverrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (rst_n=0, asynchronous) values:
  - state=IDLE.
  - {oA,oB,oC}=3'b000.
  - oData=8'h00, oValid=0, oOverrun=0.
  - slot counter=0, dwell counter=0, shift register=8'h00.
- States: IDLE, SCAN.
- IDLE:
  - select held at 000.
  - When iEnable=1 is sampled: go to SCAN with slot=0 and dwell=0.
- SCAN, per slot k:
  - {oA,oB,oC}=k for SLOT_CYCLES cycles.
  - On the last cycle of the slot (dwell==SLOT_CYCLES-1), capture iLines[k] into assembly bit k.
  - Then slot advances to k+1; slot 7 wraps to 0.
- Frame complete (sample of slot 7):
  - The assembled word, including the bit just sampled, is offered to the output register on the same edge.
  - If oValid=0, or oValid=1 with iReady=1 in that cycle: oData is loaded and oValid=1.
  - If oValid=1 and iReady=0: the new word is discarded, oData is unchanged, and oOverrun is set to 1.
  - oOverrun clears only on reset.
- Output handshake:
  - oValid clears on the edge where oValid=1 and iReady=1, unless a new word loads on the same edge, in which case oValid stays 1.
  - oData is stable while oValid=1 and iReady=0.
- Continuous scanning: after slot 7, scanning continues at slot 0 with no gap cycle while iEnable=1.
- Latency (SLOT_CYCLES=1): iEnable first seen high at edge 0 → slots occupy cycles 1..8 → oValid=1 after edge 8. In general the frame period is 8*SLOT_CYCLES.
- iEnable=0 sampled during SCAN:
  - The partial frame is discarded and the machine returns to IDLE on that edge; select goes to 000.
  - The output register and oValid are unaffected.
  - If iEnable=0 coincides with the slot-7 sample edge, the frame is still delivered.
- Reset mid-frame: all state is cleared asynchronously, and the partial word is lost.
- iLines are assumed synchronous to clk; no synchronizer is inside this block.

Optional Feature:
- Macro: TDM_LINE_CHECK_EN.
- When defined:
  - Adds output oLineErr (1 bit, reset 0).
  - At every sample point, all 7 non-selected lines must read 1; any 0 sets oLineErr sticky (cleared by reset only).
  - A word assembled during a frame with a line error is still delivered.
- When undefined: no port, no check logic; the non-selected lines are ignored.

Test Plan:
- Reset then iEnable=1, SLOT_CYCLES=1, distributor model fed 8'hA5 → select sequence 0,1,...,7 on consecutive cycles; oValid=1 after 9th edge with oData=8'hA5; oOverrun=0.
- SLOT_CYCLES=4, word 8'h3C, iReady held 1 → each select value lasts 4 cycles; oValid high for exactly 1 cycle per 32-cycle frame; oData=8'h3C each frame.
- iReady=0 across two frames (8'h11 then 8'h22) → oData stays 8'h11; oOverrun=1 after frame 2; then iReady=1 → oValid drops for one cycle.
- iReady=1 on the same edge a new word 8'h55 completes while oValid=1 with 8'h11 → oData=8'h55, oValid stays 1, oOverrun=0.
- iEnable dropped at slot 3, raised 5 cycles later → select returns to 000 immediately; the next delivered word is a full fresh frame; no partial word appears.
- (TDM_LINE_CHECK_EN) force line 6 low during slot 2 sample → oLineErr=1 and remains 1 until rst_n pulse; word still delivered.
